// File: rtl/fsm_stim.sv
// fsm_stim: drives one A high/low/high/low handshake pattern per Go and
// checks that the receiver answers with K2 after the second rise and K1
// after the final fall. Reports the outcome on Done/Err.
module fsm_stim #(
    parameter int unsigned CW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Go,
    input  logic [CW-1:0] Hold,
    input  logic          K2,
    input  logic          K1,
    output logic          A,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [2:0]    Phase
);

    localparam int unsigned TW   = $clog2(TIMEOUT);
    localparam int unsigned CNTW = (CW > TW) ? CW : TW;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI1  = 3'd1,
        LO1  = 3'd2,
        HI2  = 3'd3,
        LO2  = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   h, h_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic            got_k2, got_k2_n;
    logic            got_k1, got_k1_n;
    logic            bad, bad_n;
    logic            err_n, done_n;
    logic            phase_end;

    assign phase_end = (cnt == CNTW'(h) - CNTW'(1));
    assign Phase     = state;

    // Next-state, counter, acknowledge bookkeeping and result computation.
    // Flags are folded with this cycle's K1/K2 before the exit decision so an
    // acknowledge arriving on the leaving edge still counts.
    always_comb begin
        state_n  = state;
        h_n      = h;
        cnt_n    = cnt;
        got_k2_n = got_k2;
        got_k1_n = got_k1;
        bad_n    = bad;
        err_n    = Err;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (Go) begin
                    h_n      = (Hold == '0) ? CW'(1) : Hold;
                    cnt_n    = '0;
                    got_k2_n = 1'b0;
                    got_k1_n = 1'b0;
                    bad_n    = 1'b0;
                    err_n    = 1'b0;
                    state_n  = HI1;
                end
            end
            HI1, LO1, HI2: begin
                if (state == HI2) begin
                    if (K2) got_k2_n = 1'b1;
                    if (K1) bad_n    = 1'b1;
                end else if (K1 || K2) begin
                    bad_n = 1'b1;
                end
                if (phase_end) begin
                    cnt_n = '0;
                    case (state)
                        HI1:     state_n = LO1;
                        LO1:     state_n = HI2;
                        default: state_n = LO2;
                    endcase
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            LO2: begin
                if (K2) begin
                    if (cnt == '0) got_k2_n = 1'b1;
                    else           bad_n    = 1'b1;
                end
                if (K1) got_k1_n = 1'b1;
                if (got_k1_n || (cnt == CNTW'(TIMEOUT - 2))) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    err_n   = !(got_k2_n && got_k1_n) || bad_n;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs; synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= IDLE;
            h      <= '0;
            cnt    <= '0;
            got_k2 <= 1'b0;
            got_k1 <= 1'b0;
            bad    <= 1'b0;
            A      <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            state  <= state_n;
            h      <= h_n;
            cnt    <= cnt_n;
            got_k2 <= got_k2_n;
            got_k1 <= got_k1_n;
            bad    <= bad_n;
            A      <= (state_n == HI1) || (state_n == HI2);
            Busy   <= (state_n != IDLE);
            Done   <= done_n;
            Err    <= err_n;
        end
    end

endmodule

// File: tb/tb_fsm_stim.sv
// tb_fsm_stim: table-driven, hand-written and randomized sequences for
// fsm_stim, checked cycle by cycle against a timeline model of the handshake.
module tb_fsm_stim;

    localparam int unsigned CW = 8;
    localparam int unsigned TO = 16;

    logic          Clock = 1'b0;
    logic          Reset, Go, K1, K2;
    logic [CW-1:0] Hold;
    logic          A, Busy, Done, Err;
    logic [2:0]    Phase;

    int checks = 0;
    int errors = 0;

    // Acknowledge / Go events indexed by edge number relative to the Go edge.
    bit k1s [64];
    bit k2s [64];
    bit gos [64];

    typedef struct {
        int hold;
        int mode;
        int lat;
        bit err;
    } vec_t;

    vec_t tbl [12];

    fsm_stim #(.CW(CW), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .Hold(Hold),
        .K2(K2), .K1(K1), .A(A), .Busy(Busy), .Done(Done),
        .Err(Err), .Phase(Phase)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_ev;
        for (int i = 0; i < 64; i++) begin
            k1s[i] = 1'b0;
            k2s[i] = 1'b0;
            gos[i] = 1'b0;
        end
    endtask

    // Outcome from the acknowledge timeline: LO2 is sampled from edge 3h+1,
    // ends at the first K1 there or after TIMEOUT-1 LO2 cycles.
    function automatic void model(input int h, output int tend, output bit err);
        int lo2;
        bit k2ok, k1ok, bad;
        lo2  = 3 * h + 1;
        tend = 3 * h + int'(TO) - 1;
        for (int t = lo2; t <= 3 * h + int'(TO) - 1; t++)
            if (k1s[t]) begin
                tend = t;
                break;
            end
        k2ok = 0; k1ok = 0; bad = 0;
        for (int t = 1; t <= tend; t++) begin
            if (k2s[t]) begin
                if (t >= 2 * h + 1 && t <= lo2) k2ok = 1;
                else                            bad  = 1;
            end
            if (k1s[t]) begin
                if (t >= lo2) k1ok = 1;
                else          bad  = 1;
            end
        end
        err = !(k2ok && k1ok) || bad;
    endfunction

    task automatic set_mode(input int mode, input int h);
        clear_ev();
        case (mode)
            0: begin k2s[2*h+2] = 1; k1s[3*h+2] = 1; end
            1: begin k2s[2*h+2] = 1; end
            2: begin k1s[h+1] = 1; k2s[2*h+2] = 1; k1s[3*h+2] = 1; end
            3: begin k1s[3*h+2] = 1; end
            4: begin k1s[2*h+1] = 1; k2s[2*h+2] = 1; k1s[3*h+2] = 1; end
            5: begin k2s[3*h+2] = 1; k1s[3*h+3] = 1; end
            6: begin k2s[2*h+1] = 1; k1s[3*h+1] = 1; end
            7: begin k2s[3*h+1] = 1; k1s[3*h+1] = 1; end
            8: begin k2s[2*h+2] = 1; k1s[3*h+2] = 1; gos[2] = 1; gos[3*h] = 1; end
            default: begin k2s[2*h+2] = 1; k1s[3*h+int'(TO)-1] = 1; end
        endcase
    endtask

    task automatic run_seq(input int hold_in, input string tag, output int lat, output bit err_got);
        int h, tend, ph;
        bit err_exp;
        h = (hold_in == 0) ? 1 : hold_in;
        model(h, tend, err_exp);
        lat = -1;
        err_got = 1'b0;
        Hold = CW'(hold_in);
        K1 = 0; K2 = 0; Go = 1;
        tick();
        Go = 0;
        for (int t = 0; t <= tend; t++) begin
            if (t > 0) begin
                K1 = k1s[t];
                K2 = k2s[t];
                Go = gos[t];
                Hold = gos[t] ? CW'(7) : CW'(hold_in);
                tick();
            end
            if (t == tend)       ph = 0;
            else if (t < h)      ph = 1;
            else if (t < 2 * h)  ph = 2;
            else if (t < 3 * h)  ph = 3;
            else                 ph = 4;
            chk($sformatf("%s t%0d Phase", tag, t), int'(Phase), ph);
            chk($sformatf("%s t%0d A", tag, t), int'(A), int'(ph == 1 || ph == 3));
            chk($sformatf("%s t%0d Busy", tag, t), int'(Busy), int'(t < tend));
            chk($sformatf("%s t%0d Done", tag, t), int'(Done), int'(t == tend));
            chk($sformatf("%s t%0d Err", tag, t), int'(Err), (t == tend) ? int'(err_exp) : 0);
            if (Done === 1'b1 && lat < 0) begin
                lat = t;
                err_got = Err;
            end
        end
        // Idle cycle with acknowledges asserted: must be ignored, Err held.
        K1 = 1; K2 = 1; Go = 0; Hold = CW'(hold_in);
        tick();
        K1 = 0; K2 = 0;
        chk({tag, " idle Phase"}, int'(Phase), 0);
        chk({tag, " idle Busy"}, int'(Busy), 0);
        chk({tag, " idle Done"}, int'(Done), 0);
        chk({tag, " idle A"}, int'(A), 0);
        chk({tag, " idle Err"}, int'(Err), int'(err_exp));
    endtask

    initial begin
        int lat, h;
        bit e;

        tbl[0]  = '{hold: 3, mode: 0, lat: 11, err: 0};
        tbl[1]  = '{hold: 0, mode: 0, lat: 5,  err: 0};
        tbl[2]  = '{hold: 2, mode: 1, lat: 21, err: 1};
        tbl[3]  = '{hold: 4, mode: 2, lat: 14, err: 1};
        tbl[4]  = '{hold: 1, mode: 0, lat: 5,  err: 0};
        tbl[5]  = '{hold: 2, mode: 3, lat: 8,  err: 1};
        tbl[6]  = '{hold: 3, mode: 4, lat: 11, err: 1};
        tbl[7]  = '{hold: 3, mode: 5, lat: 12, err: 1};
        tbl[8]  = '{hold: 2, mode: 6, lat: 7,  err: 0};
        tbl[9]  = '{hold: 2, mode: 7, lat: 7,  err: 0};
        tbl[10] = '{hold: 2, mode: 8, lat: 8,  err: 0};
        tbl[11] = '{hold: 2, mode: 9, lat: 21, err: 0};

        Reset = 0; Go = 0; K1 = 0; K2 = 0; Hold = '0;
        clear_ev();
        tick();
        tick();
        Go = 1;
        Hold = CW'(3);
        tick();
        chk("rst A", int'(A), 0);
        chk("rst Busy", int'(Busy), 0);
        chk("rst Done", int'(Done), 0);
        chk("rst Err", int'(Err), 0);
        chk("rst Phase", int'(Phase), 0);
        Reset = 1; Go = 0;
        tick();
        chk("post-rst Phase", int'(Phase), 0);

        for (int i = 0; i < 12; i++) begin
            h = (tbl[i].hold == 0) ? 1 : tbl[i].hold;
            set_mode(tbl[i].mode, h);
            run_seq(tbl[i].hold, $sformatf("vec%0d", i), lat, e);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d err", i), int'(e), int'(tbl[i].err));
        end

        // Err=1 held in IDLE, then cleared by reset.
        set_mode(1, 2);
        run_seq(2, "timeout", lat, e);
        chk("timeout err", int'(e), 1);
        tick();
        chk("err held", int'(Err), 1);
        Reset = 0;
        tick();
        chk("rst idle Err", int'(Err), 0);
        Reset = 1;
        tick();

        // Reset during HI2 with Go asserted in the same cycle.
        Hold = CW'(5); Go = 1;
        tick();
        Go = 0;
        repeat (11) tick();
        chk("mid HI2 Phase", int'(Phase), 3);
        Reset = 0; Go = 1;
        tick();
        chk("mid rst A", int'(A), 0);
        chk("mid rst Busy", int'(Busy), 0);
        chk("mid rst Phase", int'(Phase), 0);
        chk("mid rst Err", int'(Err), 0);
        chk("mid rst Done", int'(Done), 0);
        Reset = 1; Go = 0;
        tick();
        chk("mid rst idle Phase", int'(Phase), 0);
        set_mode(0, 5);
        run_seq(5, "after-rst", lat, e);
        chk("after-rst latency", lat, 17);
        chk("after-rst err", int'(e), 0);

        // Randomized timelines against the model.
        for (int r = 0; r < 30; r++) begin
            int hold_r, t;
            hold_r = int'($urandom_range(0, 6));
            h = (hold_r == 0) ? 1 : hold_r;
            clear_ev();
            if ($urandom_range(0, 3) != 0) k2s[2*h + int'($urandom_range(1, 2))] = 1;
            if ($urandom_range(0, 3) != 0) k1s[3*h + int'($urandom_range(1, 3))] = 1;
            if ($urandom_range(0, 3) == 0) begin
                t = int'($urandom_range(1, 3*h + TO - 1));
                if ($urandom_range(0, 1) != 0) k1s[t] = 1;
                else                           k2s[t] = 1;
            end
            if ($urandom_range(0, 4) == 0) gos[int'($urandom_range(1, 3*h))] = 1;
            run_seq(hold_r, $sformatf("rnd%0d", r), lat, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
